// File: rtl/heartbeat_pulse_generator_if.sv
// Heartbeat pulse generator bus.
// Groups the tick strobe and heartbeat code going into the generator with the
// beat, beat_strobe and rate results coming out of it.
//   tick        : one-clk timing strobe from the shared prescaler
//   heartbeat   : 2-bit code from the upstream heartbeat model
//   beat        : double-pulse output, high during lub and dub
//   beat_strobe : one-clk pulse at the start of each period
//   rate        : code latched for the current period
interface heartbeat_pulse_generator_if;
  logic       tick;
  logic [1:0] heartbeat;
  logic       beat;
  logic       beat_strobe;
  logic [1:0] rate;

  modport master (
    output tick,
    output heartbeat,
    input  beat,
    input  beat_strobe,
    input  rate
  );

  modport slave (
    input  tick,
    input  heartbeat,
    output beat,
    output beat_strobe,
    output rate
  );
endinterface

// File: rtl/heartbeat_pulse_generator.sv
// Heartbeat pulse generator.
// Turns the 2-bit heartbeat code into a "lub-dub" double pulse per period.
// Period is selected by the code latched at each period boundary:
// 0 = P0 (fast), 1 = P1 (normal), 2 = P2 (slow), 3 = P3 (resting).
// All timing advances only on clk edges where tick is high.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : slave modport (tick, heartbeat in; beat, beat_strobe, rate out)
// Optional build macro HEARTBEAT_FLATLINE_EN: code 3 means flatline; the
// generator sits in REST with beat low and re-samples heartbeat every tick
// until a non-3 code arrives. P3 is unused in that build.
module heartbeat_pulse_generator #(
  parameter int CNT_W     = 8,
  parameter int P0        = 20,
  parameter int P1        = 40,
  parameter int P2        = 60,
  parameter int P3        = 100,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  heartbeat_pulse_generator_if.slave   bus
);

  localparam int MIN_P   = 2 * PULSE_LEN + GAP_LEN + 1;
  localparam int MAX_LEN = 2 ** CNT_W;
  localparam int FIXED   = 2 * PULSE_LEN + GAP_LEN;

  // Elaboration-time legality checks on the period/length parameters.
  if (PULSE_LEN < 1 || PULSE_LEN > MAX_LEN) begin : g_bad_pulse_len
    $error("heartbeat_pulse_generator: PULSE_LEN out of range");
  end
  if (GAP_LEN < 1 || GAP_LEN > MAX_LEN) begin : g_bad_gap_len
    $error("heartbeat_pulse_generator: GAP_LEN out of range");
  end
  if (P0 < MIN_P || (P0 - FIXED) > MAX_LEN) begin : g_bad_p0
    $error("heartbeat_pulse_generator: P0 illegal");
  end
  if (P1 < MIN_P || (P1 - FIXED) > MAX_LEN) begin : g_bad_p1
    $error("heartbeat_pulse_generator: P1 illegal");
  end
  if (P2 < MIN_P || (P2 - FIXED) > MAX_LEN) begin : g_bad_p2
    $error("heartbeat_pulse_generator: P2 illegal");
  end
`ifndef HEARTBEAT_FLATLINE_EN
  if (P3 < MIN_P || (P3 - FIXED) > MAX_LEN) begin : g_bad_p3
    $error("heartbeat_pulse_generator: P3 illegal");
  end
`endif

  typedef enum logic [1:0] {
    LUB,
    GAP,
    DUB,
    REST
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [1:0]         rate_q,  rate_d;
  logic               beat_q,  beat_d;
  logic               beat_strobe_q, beat_strobe_d;

  // Counter load value for REST: remainder of the period after lub/gap/dub.
  function automatic logic [CNT_W-1:0] rest_load(input logic [1:0] r);
    int p;
    case (r)
      2'd0:    p = P0;
      2'd1:    p = P1;
      2'd2:    p = P2;
      default: p = P3;
    endcase
    return CNT_W'(p - FIXED - 1);
  endfunction

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_LEN - 1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rate_d        = rate_q;
    beat_d        = beat_q;
    beat_strobe_d = 1'b0;

    if (bus.tick) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        case (state_q)
          LUB: begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
            beat_d  = 1'b0;
          end
          GAP: begin
            state_d = DUB;
            cnt_d   = PULSE_LOAD;
            beat_d  = 1'b1;
          end
          DUB: begin
            state_d = REST;
            cnt_d   = rest_load(rate_q);
            beat_d  = 1'b0;
          end
          default: begin
            // Period boundary: the only point where heartbeat is sampled.
            rate_d = bus.heartbeat;
`ifdef HEARTBEAT_FLATLINE_EN
            if (bus.heartbeat == 2'd3) begin
              // Flatline: park in REST with cnt=0 so the next tick re-samples.
              state_d = REST;
              cnt_d   = '0;
              beat_d  = 1'b0;
            end else begin
              state_d       = LUB;
              cnt_d         = PULSE_LOAD;
              beat_d        = 1'b1;
              beat_strobe_d = 1'b1;
            end
`else
            state_d       = LUB;
            cnt_d         = PULSE_LOAD;
            beat_d        = 1'b1;
            beat_strobe_d = 1'b1;
`endif
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= REST;
      cnt_q         <= '0;
      rate_q        <= 2'd3;
      beat_q        <= 1'b0;
      beat_strobe_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rate_q        <= rate_d;
      beat_q        <= beat_d;
      beat_strobe_q <= beat_strobe_d;
    end
  end

  assign bus.beat        = beat_q;
  assign bus.beat_strobe = beat_strobe_q;
  assign bus.rate        = rate_q;

endmodule

// File: tb/tb_heartbeat_pulse_generator.sv
module tb_heartbeat_pulse_generator;

  localparam int CNT_W = 8;
  localparam int P0 = 20;
  localparam int P1 = 40;
  localparam int P2 = 60;
  localparam int P3 = 100;
  localparam int PL = 4;
  localparam int GL = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  heartbeat_pulse_generator_if bus ();

  heartbeat_pulse_generator #(
    .CNT_W(CNT_W), .P0(P0), .P1(P1), .P2(P2), .P3(P3),
    .PULSE_LEN(PL), .GAP_LEN(GL)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the period in ticks (-1 = at boundary).
  int         m_pos;
  logic [1:0] m_rate;
  logic       m_beat;
  logic       m_strobe;
  logic [3:0] sb[$];  // {beat, beat_strobe, rate}

  function automatic int p_of(input logic [1:0] r);
    case (r)
      2'd0:    return P0;
      2'd1:    return P1;
      2'd2:    return P2;
      default: return P3;
    endcase
  endfunction

  // Drive one cycle of stimulus, advance the model, push the expectation,
  // then step past the clock edge.
  task automatic drive_cycle(input logic r, input logic t, input logic [1:0] h);
    rst = r;
    bus.tick = t;
    bus.heartbeat = h;
    if (r) begin
      m_rate = 2'd3; m_beat = 1'b0; m_strobe = 1'b0; m_pos = -1;
    end else if (t) begin
      if (m_pos < 0 || m_pos == p_of(m_rate) - 1) begin
`ifdef HEARTBEAT_FLATLINE_EN
        if (h == 2'd3) begin
          m_rate = 2'd3; m_beat = 1'b0; m_strobe = 1'b0; m_pos = -1;
        end else begin
`else
        begin
`endif
          m_rate = h; m_pos = 0; m_beat = 1'b1; m_strobe = 1'b1;
        end
      end else begin
        m_pos++;
        m_beat = (m_pos < PL) || (m_pos >= PL + GL && m_pos < 2 * PL + GL);
        m_strobe = 1'b0;
      end
    end else begin
      m_strobe = 1'b0;
    end
    sb.push_back({m_beat, m_strobe, m_rate});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp, got;
    // Reset together with tick: reset values, no strobe.
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b1, 2'd1);
      exp = sb.pop_front();
      got = {bus.beat, bus.beat_strobe, bus.rate};
      checks++;
      if (got !== exp || got !== 4'b0011) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got=%b exp=%b", i, got, 4'b0011);
      end
    end
  endtask

  task automatic test_normal();
    logic [3:0] exp, got;
    int strobes;
    strobes = 0;
    for (int i = 0; i < 120; i++) begin
      drive_cycle(1'b0, 1'b1, 2'd1);
      exp = sb.pop_front();
      got = {bus.beat, bus.beat_strobe, bus.rate};
      if (got[2]) strobes++;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL normal cyc=%0d got=%b exp=%b", i, got, exp);
      end
    end
    checks++;
    if (strobes !== 3) begin
      failures++;
      $display("FAIL normal_strobe_count got=%0d exp=3", strobes);
    end
  endtask

  task automatic test_rate_switch();
    logic [3:0] exp, got;
    drive_cycle(1'b1, 1'b0, 2'd1);
    void'(sb.pop_front());
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b0, 1'b1, (i >= 10) ? 2'd0 : 2'd1);
      exp = sb.pop_front();
      got = {bus.beat, bus.beat_strobe, bus.rate};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL rate_switch cyc=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_slow_tick();
    logic [3:0] exp, got;
    int last_strobe, gap_seen;
    drive_cycle(1'b1, 1'b0, 2'd2);
    void'(sb.pop_front());
    last_strobe = -1;
    for (int i = 0; i < 500; i++) begin
      drive_cycle(1'b0, (i % 4) == 0, 2'd2);
      exp = sb.pop_front();
      got = {bus.beat, bus.beat_strobe, bus.rate};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL slow_tick cyc=%0d got=%b exp=%b", i, got, exp);
      end
      if (got[2]) begin
        if (last_strobe >= 0) begin
          gap_seen = i - last_strobe;
          checks++;
          if (gap_seen !== 240) begin
            failures++;
            $display("FAIL slow_tick_spacing got=%0d exp=240", gap_seen);
          end
        end
        last_strobe = i;
      end
    end
  endtask

  task automatic test_code3();
    logic [3:0] exp, got;
    int strobes, exp_strobes;
    drive_cycle(1'b1, 1'b0, 2'd3);
    void'(sb.pop_front());
    strobes = 0;
`ifdef HEARTBEAT_FLATLINE_EN
    exp_strobes = 0;
`else
    exp_strobes = 5;
`endif
    for (int i = 0; i < 500; i++) begin
      drive_cycle(1'b0, 1'b1, 2'd3);
      exp = sb.pop_front();
      got = {bus.beat, bus.beat_strobe, bus.rate};
      if (got[2]) strobes++;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL code3 cyc=%0d got=%b exp=%b", i, got, exp);
      end
    end
    checks++;
    if (strobes !== exp_strobes) begin
      failures++;
      $display("FAIL code3_strobe_count got=%0d exp=%0d", strobes, exp_strobes);
    end
    strobes = 0;
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b0, 1'b1, 2'd0);
      exp = sb.pop_front();
      got = {bus.beat, bus.beat_strobe, bus.rate};
      if (got[2]) strobes++;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL code3_recover cyc=%0d got=%b exp=%b", i, got, exp);
      end
    end
    checks++;
    if (strobes !== 5) begin
      failures++;
      $display("FAIL code3_recover_count got=%0d exp=5", strobes);
    end
  endtask

  task automatic test_reset_mid_dub();
    logic [3:0] exp, got;
    drive_cycle(1'b1, 1'b0, 2'd1);
    void'(sb.pop_front());
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 1'b1, 2'd1);
      exp = sb.pop_front();
      got = {bus.beat, bus.beat_strobe, bus.rate};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL pre_dub cyc=%0d got=%b exp=%b", i, got, exp);
      end
    end
    // Now in DUB with beat high; reset with tick high.
    drive_cycle(1'b1, 1'b1, 2'd1);
    exp = sb.pop_front();
    got = {bus.beat, bus.beat_strobe, bus.rate};
    checks++;
    if (got !== exp || got !== 4'b0011) begin
      failures++;
      $display("FAIL reset_mid_dub got=%b exp=%b", got, 4'b0011);
    end
    drive_cycle(1'b0, 1'b1, 2'd2);
    exp = sb.pop_front();
    got = {bus.beat, bus.beat_strobe, bus.rate};
    checks++;
    if (got !== exp || got !== 4'b1110) begin
      failures++;
      $display("FAIL post_reset_lub got=%b exp=%b", got, 4'b1110);
    end
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b0, 1'b1, 2'd2);
      exp = sb.pop_front();
      got = {bus.beat, bus.beat_strobe, bus.rate};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL post_reset cyc=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.heartbeat = 2'd0;
    m_pos = -1; m_rate = 2'd3; m_beat = 1'b0; m_strobe = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_normal();
    test_rate_switch();
    test_slow_tick();
    test_code3();
    test_reset_mid_dub();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
